// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - shared-memory arbiter between instruction fetch and data access
module mem_arbiter_ctrl #(
  parameter int unsigned WAIT_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  input  logic        d_en,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  input  logic        halt,
  input  logic        mem_ready,
  input  logic [15:0] mem_rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_createdump,
  output logic        if_done,
  output logic        d_done,
  output logic [15:0] if_rdata,
  output logic [15:0] d_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        halted,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_FETCH,
    S_DUMP,
    S_HALTED
  } state_t;

  // Last count value before the access is declared timed out.
  localparam logic [3:0] LIMIT_M1 = 4'(WAIT_LIMIT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       run;        // low for the first edge after reset release
  logic       halt_pend;  // halt seen while an access was busy

  // Pipeline stalls follow the request levels until the matching done pulse.
  assign stall_if  = if_req & ~if_done & ~halted;
  assign stall_mem = d_en & ~d_done;

  // Arbitration FSM with registered memory-side and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      wait_cnt       <= 4'd0;
      run            <= 1'b0;
      halt_pend      <= 1'b0;
      mem_en         <= 1'b0;
      mem_wr         <= 1'b0;
      mem_addr       <= 16'h0000;
      mem_wdata      <= 16'h0000;
      mem_createdump <= 1'b0;
      if_done        <= 1'b0;
      d_done         <= 1'b0;
      if_rdata       <= 16'h0000;
      d_rdata        <= 16'h0000;
      halted         <= 1'b0;
      err            <= 1'b0;
    end else begin
      if_done        <= 1'b0;
      d_done         <= 1'b0;
      mem_createdump <= 1'b0;
      run            <= 1'b1;
      case (state)
        S_IDLE: begin
          // Requests still high during their own done cycle are not re-issued.
          if (run) begin
            if (d_en && !d_done) begin
              state     <= S_DATA;
              mem_en    <= 1'b1;
              mem_wr    <= d_wr;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              wait_cnt  <= 4'd0;
            end else if (halt || halt_pend) begin
              state          <= S_DUMP;
              mem_createdump <= 1'b1;
              halt_pend      <= 1'b0;
            end else if (if_req && !if_done) begin
              state     <= S_FETCH;
              mem_en    <= 1'b1;
              mem_wr    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= 16'h0000;
              wait_cnt  <= 4'd0;
            end
          end
        end
        S_DATA: begin
          if (halt) halt_pend <= 1'b1;
          if (mem_ready) begin
            if (!mem_wr) d_rdata <= mem_rdata;
            d_done <= 1'b1;
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            state  <= S_IDLE;
          end else if (wait_cnt == LIMIT_M1) begin
            err     <= 1'b1;
            d_rdata <= 16'h0000;
            d_done  <= 1'b1;
            mem_en  <= 1'b0;
            mem_wr  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_FETCH: begin
          if (halt) halt_pend <= 1'b1;
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_done  <= 1'b1;
            mem_en   <= 1'b0;
            state    <= S_IDLE;
          end else if (wait_cnt == LIMIT_M1) begin
            err      <= 1'b1;
            if_rdata <= 16'h0000;
            if_done  <= 1'b1;
            mem_en   <= 1'b0;
            state    <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_DUMP: begin
          halted <= 1'b1;
          state  <= S_HALTED;
        end
        S_HALTED: begin
          state <= S_HALTED;
        end
        default: begin
          state  <= S_IDLE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
        end
      endcase
    end
  end

endmodule
